// File: rtl/count_bcd_display_if.sv
// count_bcd_display_if
//   Bundles the data and status signals between an upstream counter, the
//   BCD/seven-segment display block and whatever observes the display.
//   value     : 8-bit binary value to be shown (driven by master)
//   bcd       : last converted result {hundreds, tens, ones}
//   bcd_valid : one-cycle pulse when bcd is updated
//   busy      : conversion in progress
//   seg       : segments {g,f,e,d,c,b,a}, active-low
//   an        : digit anodes {hundreds, tens, ones}, one-hot active-low
//   master = value source / display observer, slave = the display block.
interface count_bcd_display_if;
    logic [7:0]  value;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic        busy;
    logic [6:0]  seg;
    logic [2:0]  an;

    modport master (
        output value,
        input  bcd,
        input  bcd_valid,
        input  busy,
        input  seg,
        input  an
    );

    modport slave (
        input  value,
        output bcd,
        output bcd_valid,
        output busy,
        output seg,
        output an
    );
endinterface

// File: rtl/count_bcd_display.sv
// count_bcd_display
//   Converts an 8-bit binary value to three BCD digits with a sequential
//   shift-add-3 (double-dabble) engine and drives a time-multiplexed 3-digit
//   seven-segment display with leading-zero blanking.
//   clk         : system clock, all state on the rising edge
//   rst         : asynchronous active-high reset
//   bus (slave) : value in; bcd, bcd_valid, busy, seg, an out
//   REFRESH_DIV : clock cycles each digit stays lit (>= 2)
module count_bcd_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    count_bcd_display_if.slave   bus
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] shift_q, shift_d;
    logic [7:0]  last_value_q, last_value_d;
    logic [2:0]  step_q, step_d;
    logic [11:0] bcd_q, bcd_d;
    logic        bcd_valid_q, bcd_valid_d;

    logic [CNT_W-1:0] refresh_q, refresh_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic [2:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    // Seven-segment pattern (gfedcba, active-low) for one BCD nibble.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // One double-dabble step: add 3 to every BCD nibble that is >= 5 (all
    // three judged on their pre-shift values), then shift left by one. The
    // add stays within 4 bits, so nothing carries between nibbles.
    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] t;
        logic [3:0]  nib;
        t = s;
        for (int i = 0; i < 3; i++) begin
            nib = s[8 + 4*i +: 4];
            if (nib >= 4'd5) begin
                t[8 + 4*i +: 4] = nib + 4'd3;
            end
        end
        return {t[18:0], 1'b0};
    endfunction

    // Conversion FSM: next state and datapath updates.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        last_value_d = last_value_q;
        step_d       = step_q;
        bcd_d        = bcd_q;
        bcd_valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // last_value remembers the latched value, so a change made
                // while busy is still seen here once IDLE is re-entered.
                if (bus.value != last_value_q) begin
                    last_value_d = bus.value;
                    shift_d      = {12'b0, bus.value};
                    step_d       = 3'd0;
                    state_d      = CONVERT;
                end
            end
            CONVERT: begin
                shift_d = dabble_step(shift_q);
                step_d  = step_q + 3'd1;
                if (step_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d       = shift_q[19:8];
                bcd_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Display scan: refresh divider, digit index and the next an/seg pair.
    // The display always reads the committed bcd register, never the
    // in-flight shift register.
    always_comb begin
        refresh_d   = refresh_q + CNT_W'(1);
        digit_idx_d = digit_idx_q;
        if (refresh_q == REFRESH_LAST) begin
            refresh_d   = '0;
            digit_idx_d = (digit_idx_q == 2'd2) ? 2'd0 : digit_idx_q + 2'd1;
        end

        an_d  = 3'b110;
        seg_d = seg_decode(bcd_q[3:0]);
        case (digit_idx_q)
            2'd1: begin
                an_d  = 3'b101;
                seg_d = (bcd_q[11:8] == 4'd0 && bcd_q[7:4] == 4'd0)
                        ? SEG_BLANK : seg_decode(bcd_q[7:4]);
            end
            2'd2: begin
                an_d  = 3'b011;
                seg_d = (bcd_q[11:8] == 4'd0) ? SEG_BLANK : seg_decode(bcd_q[11:8]);
            end
            default: begin
                an_d  = 3'b110;
                seg_d = seg_decode(bcd_q[3:0]);
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            last_value_q <= '0;
            step_q       <= '0;
            bcd_q        <= '0;
            bcd_valid_q  <= 1'b0;
            refresh_q    <= '0;
            digit_idx_q  <= '0;
            an_q         <= 3'b110;
            seg_q        <= 7'b1000000;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            last_value_q <= last_value_d;
            step_q       <= step_d;
            bcd_q        <= bcd_d;
            bcd_valid_q  <= bcd_valid_d;
            refresh_q    <= refresh_d;
            digit_idx_q  <= digit_idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign bus.bcd       = bcd_q;
    assign bus.bcd_valid = bcd_valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.seg       = seg_q;
    assign bus.an        = an_q;

endmodule
